// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALUOp/funct into a 3-bit ALU control code and issues it over a valid/ready handshake, holding MUL ops for MUL_LAT cycles.
//   Ports: clk_i, rst_i (sync, active-high), valid_i/ALUOp_i/funct_i (op in), stall_i (downstream hold),
//   ready_o (accept), ALUCtrl_o/valid_o (issued op), busy_o (MUL window), illegal_o (unknown R-type funct).
//   Optional: define ALU_ISSUE_ILLEGAL_EN to drive illegal_o; otherwise it stays 0.
module alu_ctrl_issue #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] ALUOp_i,
  input  logic [5:0] funct_i,
  input  logic       stall_i,
  output logic       ready_o,
  output logic [2:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       illegal_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
  localparam bit MULTI = MUL_LAT > 1;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] r_code, code;
  logic is_mul, ill, accept, at_last;
  assign r_code = funct_i == 6'b100000 ? 3'b010 :
                  funct_i == 6'b100010 ? 3'b110 :
                  funct_i == 6'b100100 ? 3'b000 :
                  funct_i == 6'b100101 ? 3'b001 :
                  funct_i == 6'b011000 ? 3'b111 : 3'b100;
  assign code = ALUOp_i == 2'b00 ? 3'b010 :
                ALUOp_i == 2'b01 ? 3'b110 :
                ALUOp_i == 2'b11 ? 3'b001 : r_code;
  assign is_mul = ALUOp_i == 2'b10 && funct_i == 6'b011000;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign ill = ALUOp_i == 2'b10 &&
               !(funct_i inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000});
`else
  assign ill = 1'b0;
`endif
  assign at_last = cnt == CNT_LAST;
  assign ready_o = state == S_IDLE  ? 1'b1 :
                   state == S_ISSUE ? !stall_i :
                   state == S_MUL   ? at_last && !stall_i : 1'b0;
  assign accept = valid_i && ready_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      ALUCtrl_o <= 3'b100;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      illegal_o <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      state     <= (is_mul && MULTI) ? S_MUL : S_ISSUE;
      ALUCtrl_o <= code;
      valid_o   <= 1'b1;
      busy_o    <= is_mul && MULTI;
      illegal_o <= ill;
      cnt       <= '0;
    end else if (stall_i && state != S_IDLE) begin
      state <= state;
    end else if (state == S_MUL && !at_last) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      state     <= S_IDLE;
      ALUCtrl_o <= 3'b100;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      illegal_o <= 1'b0;
      cnt       <= '0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed self-checking bench for alu_ctrl_issue (MUL_LAT=4 and MUL_LAT=1 instances).
module tb_alu_ctrl_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0, stall = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] fn = 6'b000000;
  logic ready, vo, busy, ill;
  logic [2:0] ctrl;
  logic valid1 = 1'b0, stall1 = 1'b0;
  logic [1:0] op1 = 2'b00;
  logic [5:0] fn1 = 6'b000000;
  logic ready1, vo1, busy1, ill1;
  logic [2:0] ctrl1;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MUL_LAT(4), .CNT_W(4)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(op), .funct_i(fn), .stall_i(stall),
    .ready_o(ready), .ALUCtrl_o(ctrl), .valid_o(vo), .busy_o(busy), .illegal_o(ill));

  alu_ctrl_issue #(.MUL_LAT(1), .CNT_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ALUOp_i(op1), .funct_i(fn1), .stall_i(stall1),
    .ready_o(ready1), .ALUCtrl_o(ctrl1), .valid_o(vo1), .busy_o(busy1), .illegal_o(ill1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++;
    if ({ready, vo, ctrl, busy, ill} !== 7'b1_0_100_0_0) begin
      n_fail++;
      $display("FAIL por_state: got rdy/v/ctrl/busy/ill=%b exp 1_0_100_0_0", {ready, vo, ctrl, busy, ill});
    end
    valid = 1'b1; op = 2'b10; fn = 6'b011000;
    tick();
    valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({vo, ctrl, busy} !== 5'b1_111_1) begin
      n_fail++;
      $display("FAIL mul_before_reset: got v/ctrl/busy=%b exp 1_111_1", {vo, ctrl, busy});
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({ready, vo, ctrl, busy, ill} !== 7'b1_0_100_0_0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got rdy/v/ctrl/busy/ill=%b exp 1_0_100_0_0", {ready, vo, ctrl, busy, ill});
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [2:0] exp [4] = '{3'b010, 3'b110, 3'b001, 3'b000};
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; op = ops[i]; fn = 6'b100100;
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b exp 1", i, ready);
      end
      tick();
      n_checks++;
      if ({vo, ctrl, busy} !== {1'b1, exp[i], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got v/ctrl/busy=%b exp %b", i, {vo, ctrl, busy}, {1'b1, exp[i], 1'b0});
      end
    end
    valid = 1'b0;
    tick();
    n_checks++;
    if ({vo, ctrl} !== 4'b0_100) begin
      n_fail++;
      $display("FAIL b2b_idle: got v/ctrl=%b exp 0_100", {vo, ctrl});
    end
  endtask

  task automatic test_mul;
    valid = 1'b1; op = 2'b10; fn = 6'b011000;
    tick();
    op = 2'b00; fn = 6'b000000;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if ({ready, vo, ctrl, busy} !== {i == 4, 5'b1_111_1}) begin
        n_fail++;
        $display("FAIL mul_cycle[%0d]: got rdy/v/ctrl/busy=%b exp %b", i, {ready, vo, ctrl, busy}, {i == 4, 5'b1_111_1});
      end
      tick();
    end
    valid = 1'b0;
    n_checks++;
    if ({vo, ctrl, busy} !== 5'b1_010_0) begin
      n_fail++;
      $display("FAIL mul_then_add: got v/ctrl/busy=%b exp 1_010_0", {vo, ctrl, busy});
    end
    tick();
  endtask

  task automatic test_stall;
    int win = 0;
    valid = 1'b1; op = 2'b10; fn = 6'b011000;
    tick();
    valid = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ready, vo, ctrl, busy} !== 6'b0_1_111_1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got rdy/v/ctrl/busy=%b exp 0_1_111_1", i, {ready, vo, ctrl, busy});
      end
    end
    stall = 1'b0;
    win = 5;
    for (int i = 0; i < 20 && busy; i++) begin
      tick();
      if (busy) win++;
    end
    n_checks++;
    if (win !== 7 || busy !== 1'b0 || vo !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_window: got %0d cycles busy=%b v=%b exp 7 cycles busy=0 v=0", win, busy, vo);
    end
  endtask

  task automatic test_illegal;
    logic exp_ill;
`ifdef ALU_ISSUE_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    valid = 1'b1; op = 2'b10; fn = 6'b101010;
    tick();
    valid = 1'b0;
    n_checks++;
    if ({vo, ctrl, ill} !== {4'b1_100, exp_ill}) begin
      n_fail++;
      $display("FAIL illegal_flag: got v/ctrl/ill=%b exp %b", {vo, ctrl, ill}, {4'b1_100, exp_ill});
    end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    n_checks++;
    if ({vo, ill} !== {1'b1, exp_ill}) begin
      n_fail++;
      $display("FAIL illegal_stall: got v/ill=%b exp %b", {vo, ill}, {1'b1, exp_ill});
    end
    tick();
    n_checks++;
    if ({vo, ctrl, ill} !== 5'b0_100_0) begin
      n_fail++;
      $display("FAIL illegal_clear: got v/ctrl/ill=%b exp 0_100_0", {vo, ctrl, ill});
    end
    valid = 1'b1; op = 2'b11; fn = 6'b101010;
    tick();
    valid = 1'b0;
    n_checks++;
    if ({vo, ctrl, ill} !== 5'b1_001_0) begin
      n_fail++;
      $display("FAIL illegal_non_rtype: got v/ctrl/ill=%b exp 1_001_0", {vo, ctrl, ill});
    end
    tick();
  endtask

  task automatic test_mul_lat1;
    valid1 = 1'b1; op1 = 2'b10; fn1 = 6'b011000;
    tick();
    op1 = 2'b11; fn1 = 6'b000000;
    n_checks++;
    if ({ready1, vo1, ctrl1, busy1} !== 6'b1_1_111_0) begin
      n_fail++;
      $display("FAIL lat1_mul: got rdy/v/ctrl/busy=%b exp 1_1_111_0", {ready1, vo1, ctrl1, busy1});
    end
    tick();
    valid1 = 1'b0;
    n_checks++;
    if ({vo1, ctrl1, busy1} !== 5'b1_001_0) begin
      n_fail++;
      $display("FAIL lat1_or: got v/ctrl/busy=%b exp 1_001_0", {vo1, ctrl1, busy1});
    end
    tick();
    n_checks++;
    if ({vo1, ctrl1, busy1} !== 5'b0_100_0) begin
      n_fail++;
      $display("FAIL lat1_idle: got v/ctrl/busy=%b exp 0_100_0", {vo1, ctrl1, busy1});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_stall();
    test_illegal();
    test_mul_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
